// File: rtl/hvac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : hvac_sequencer_if
//  Purpose  : Signal bundle between the thermostat core (master) and the
//             HVAC sequencer (slave).
//  Signals  : tick        - timebase pulse, one clk wide
//             Enable      - 1 = sequencing allowed
//             CurrentTemp - measured temperature, unsigned 8 bit
//             DesiredTemp - setpoint, unsigned 8 bit
//             FanOn       - manual fan request in IDLE (HVAC_FAN_ON_EN only)
//             Heat/Cool/Fan - registered relay drives
//             Fault       - sensor out of range
//             State       - 3-bit FSM state encoding
//  Config   : HVAC_FAN_ON_EN adds the FanOn signal.
//  Revision : 1.0 - initial release
// ============================================================================
interface hvac_sequencer_if;
   logic       tick;
   logic       Enable;
   logic [7:0] CurrentTemp;
   logic [7:0] DesiredTemp;
`ifdef HVAC_FAN_ON_EN
   logic       FanOn;
`endif
   logic       Heat;
   logic       Cool;
   logic       Fan;
   logic       Fault;
   logic [2:0] State;

   modport master (
`ifdef HVAC_FAN_ON_EN
      output FanOn,
`endif
      output tick, Enable, CurrentTemp, DesiredTemp,
      input  Heat, Cool, Fan, Fault, State
   );

   modport slave (
`ifdef HVAC_FAN_ON_EN
      input  FanOn,
`endif
      input  tick, Enable, CurrentTemp, DesiredTemp,
      output Heat, Cool, Fan, Fault, State
   );
endinterface
`default_nettype wire

// File: rtl/hvac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hvac_sequencer
//  Purpose  : Sequences heating/cooling relays from current/desired
//             temperature with a hysteresis band, minimum on-time,
//             post-purge off-time lockout and fan purge.
//  Ports    : clk      - system clock
//             Reset_n  - asynchronous active-low reset
//             hvac_io  - hvac_sequencer_if.slave bundle (tick, Enable,
//                        CurrentTemp, DesiredTemp, [FanOn], Heat, Cool,
//                        Fan, Fault, State)
//  Config   : HVAC_FAN_ON_EN - when defined, FanOn drives Fan in IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module hvac_sequencer #(
   parameter int HYST      = 1,
   parameter int MIN_ON    = 60,
   parameter int MIN_OFF   = 120,
   parameter int FAN_PURGE = 30,
   parameter int TEMP_MAX  = 99
) (
   input  wire logic       clk,
   input  wire logic       Reset_n,
   hvac_sequencer_if.slave hvac_io
);

   localparam logic [15:0] c_MIN_ON    = 16'(MIN_ON);
   localparam logic [15:0] c_MIN_OFF   = 16'(MIN_OFF);
   localparam logic [15:0] c_FAN_PURGE = 16'(FAN_PURGE);
   localparam logic [8:0]  c_HYST      = 9'(HYST);
   localparam logic [8:0]  c_TEMP_MAX  = 9'(TEMP_MAX);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEAT   = 3'd1,
      S_HPURGE = 3'd2,
      S_COOL   = 3'd3,
      S_CPURGE = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        heat_q, heat_d;
   logic        cool_q, cool_d;
   logic        fan_q, fan_d;
   logic        fault_q, fault_d;

   logic        w_load;
   logic [15:0] w_load_val;
   logic        w_timer_zero;
   logic [8:0]  w_cur, w_des;
   logic        w_heat_dem, w_cool_dem, w_temp_bad;
   logic        w_idle_fan;

   // Widen to 9 bits so cur+HYST / des+HYST cannot wrap.
   assign w_cur        = {1'b0, hvac_io.CurrentTemp};
   assign w_des        = {1'b0, hvac_io.DesiredTemp};
   assign w_heat_dem   = (w_cur + c_HYST) < w_des;
   assign w_cool_dem   = w_cur > (w_des + c_HYST);
   assign w_temp_bad   = w_cur > c_TEMP_MAX;
   assign w_timer_zero = (timer_q == 16'd0);

`ifdef HVAC_FAN_ON_EN
   assign w_idle_fan = hvac_io.FanOn;
`else
   assign w_idle_fan = 1'b0;
`endif

   // Next-state and timer-load decision
   always_comb begin
      state_d    = state_q;
      w_load     = 1'b0;
      w_load_val = 16'd0;
      case (state_q)
         S_IDLE: begin
            if (hvac_io.Enable && w_timer_zero) begin
               if (w_heat_dem) begin
                  state_d    = S_HEAT;
                  w_load     = 1'b1;
                  w_load_val = c_MIN_ON;
               end else if (w_cool_dem) begin
                  state_d    = S_COOL;
                  w_load     = 1'b1;
                  w_load_val = c_MIN_ON;
               end
            end
         end
         S_HEAT: begin
            // Enable drop bypasses the minimum on-time.
            if (((w_cur >= w_des) && w_timer_zero) || !hvac_io.Enable) begin
               state_d    = S_HPURGE;
               w_load     = 1'b1;
               w_load_val = c_FAN_PURGE;
            end
         end
         S_COOL: begin
            if (((w_cur <= w_des) && w_timer_zero) || !hvac_io.Enable) begin
               state_d    = S_CPURGE;
               w_load     = 1'b1;
               w_load_val = c_FAN_PURGE;
            end
         end
         S_HPURGE, S_CPURGE: begin
            if (w_timer_zero) begin
               state_d    = S_IDLE;
               w_load     = 1'b1;
               w_load_val = c_MIN_OFF;
            end
         end
         S_FAULT: begin
            if (!w_temp_bad) begin
               state_d    = S_IDLE;
               w_load     = 1'b1;
               w_load_val = c_MIN_OFF;
            end
         end
         default: state_d = S_IDLE;  // 6/7 recover to IDLE
      endcase

      // Sensor fault pre-empts every other decision.
      if (w_temp_bad) begin
         state_d    = S_FAULT;
         w_load     = 1'b0;
         w_load_val = 16'd0;
      end
   end

   // Timer: a load wins over a tick; counting saturates at zero.
   always_comb begin
      timer_d = timer_q;
      if (w_load) begin
         timer_d = w_load_val;
      end else if (hvac_io.tick && !w_timer_zero) begin
         timer_d = timer_q - 16'd1;
      end
   end

   // Relay values are decoded from the next state so they register together.
   always_comb begin
      heat_d  = (state_d == S_HEAT);
      cool_d  = (state_d == S_COOL);
      fault_d = (state_d == S_FAULT);
      case (state_d)
         S_HEAT, S_COOL, S_HPURGE, S_CPURGE: fan_d = 1'b1;
         S_IDLE:                             fan_d = w_idle_fan;
         default:                            fan_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         timer_q <= 16'd0;
         heat_q  <= 1'b0;
         cool_q  <= 1'b0;
         fan_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         heat_q  <= heat_d;
         cool_q  <= cool_d;
         fan_q   <= fan_d;
         fault_q <= fault_d;
      end
   end

   assign hvac_io.Heat  = heat_q;
   assign hvac_io.Cool  = cool_q;
   assign hvac_io.Fan   = fan_q;
   assign hvac_io.Fault = fault_q;
   assign hvac_io.State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hvac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hvac_sequencer
//  Purpose  : Directed self-checking bench for hvac_sequencer
//             (HYST=1 MIN_ON=4 MIN_OFF=6 FAN_PURGE=2 TEMP_MAX=99,
//             tick every 4 clk).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hvac_sequencer;

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_HEAT   = 3'd1;
   localparam logic [2:0] c_HPURGE = 3'd2;
   localparam logic [2:0] c_COOL   = 3'd3;
   localparam logic [2:0] c_CPURGE = 3'd4;
   localparam logic [2:0] c_FAULT  = 3'd5;

   logic clk = 1'b0;
   logic Reset_n;
   int   total = 0;
   int   bad   = 0;
   int   phase = 0;
   int   nt;

   always #5 clk = ~clk;

   hvac_sequencer_if u_if ();

   hvac_sequencer #(
      .HYST      (1),
      .MIN_ON    (4),
      .MIN_OFF   (6),
      .FAN_PURGE (2),
      .TEMP_MAX  (99)
   ) dut (
      .clk     (clk),
      .Reset_n (Reset_n),
      .hvac_io (u_if.slave)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // State plus {Heat,Cool,Fan,Fault}
   task automatic outs(input string tag, input logic [2:0] st,
                       input logic h, input logic c, input logic f, input logic flt);
      check({tag, "_state"}, {13'd0, u_if.State}, {13'd0, st});
      check({tag, "_relays"}, {12'd0, u_if.Heat, u_if.Cool, u_if.Fan, u_if.Fault},
            {12'd0, h, c, f, flt});
   endtask

   // One clock; tick is asserted on every fourth clock.
   task automatic step(output logic ticked);
      ticked    = (phase == 3);
      u_if.tick = ticked;
      phase     = (phase + 1) % 4;
      @(posedge clk);
      #1;
      u_if.tick = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      int   seen;
      logic t;
      seen = 0;
      while (seen < n) begin
         step(t);
         if (t) seen++;
      end
   endtask

   // Clock until State reaches st (bounded), returning ticks applied on the way.
   task automatic run_until(input string tag, input logic [2:0] st, output int nticks);
      logic t;
      nticks = 0;
      for (int i = 0; i < 200; i++) begin
         step(t);
         if (t) nticks++;
         if (u_if.State === st) break;
      end
      check({tag, "_reached"}, {13'd0, u_if.State}, {13'd0, st});
   endtask

   initial begin
      logic t;
      u_if.tick        = 1'b0;
      u_if.Enable      = 1'b1;
      u_if.DesiredTemp = 8'd72;
      u_if.CurrentTemp = 8'd72;
`ifdef HVAC_FAN_ON_EN
      u_if.FanOn       = 1'b0;
`endif
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #1 outs("reset", c_IDLE, 0, 0, 0, 0);
      #20 Reset_n = 1'b1;

      // Deadband: no demand at 71/72/73 against 72
      u_if.CurrentTemp = 8'd71; wait_ticks(2); outs("dead71", c_IDLE, 0, 0, 0, 0);
      u_if.CurrentTemp = 8'd72; wait_ticks(2); outs("dead72", c_IDLE, 0, 0, 0, 0);
      u_if.CurrentTemp = 8'd73; wait_ticks(2); outs("dead73", c_IDLE, 0, 0, 0, 0);

      // Heat cycle: starts immediately (no lockout after reset)
      u_if.CurrentTemp = 8'd69;
      step(t);
      outs("heat_start", c_HEAT, 1, 0, 1, 0);
      wait_ticks(2);
      outs("heat_mid", c_HEAT, 1, 0, 1, 0);
      u_if.CurrentTemp = 8'd72;          // satisfied, but MIN_ON not yet over
      run_until("heat_end", c_HPURGE, nt);
      check("heat_rest_ticks", 16'(nt), 16'd2);
      outs("hpurge", c_HPURGE, 0, 0, 1, 0);
      run_until("hpurge_end", c_IDLE, nt);
      check("hpurge_ticks", 16'(nt), 16'd2);
      outs("idle_after_heat", c_IDLE, 0, 0, 0, 0);

      // Lockout before cooling
      u_if.CurrentTemp = 8'd80;
      run_until("lockout_cool", c_COOL, nt);
      check("lockout_ticks", 16'(nt), 16'd6);
      outs("cool_on", c_COOL, 0, 1, 1, 0);

      // Enable drop overrides MIN_ON
      wait_ticks(1);
      u_if.Enable = 1'b0;
      step(t);
      outs("enable_drop", c_CPURGE, 0, 0, 1, 0);
      run_until("cpurge_end", c_IDLE, nt);
      check("cpurge_ticks", 16'(nt), 16'd2);
      u_if.Enable = 1'b1;
      run_until("recool", c_COOL, nt);
      check("recool_ticks", 16'(nt), 16'd6);

      // Normal cool exit at MIN_ON
      u_if.CurrentTemp = 8'd72;
      run_until("cool_end", c_CPURGE, nt);
      check("cool_min_on_ticks", 16'(nt), 16'd4);
      run_until("cpurge2_end", c_IDLE, nt);
      check("cpurge2_ticks", 16'(nt), 16'd2);

      // Reversal to heat passes full lockout
      u_if.CurrentTemp = 8'd69;
      run_until("reheat", c_HEAT, nt);
      check("reheat_ticks", 16'(nt), 16'd6);
      outs("reheat_on", c_HEAT, 1, 0, 1, 0);

      // Sensor fault from HEAT
      u_if.CurrentTemp = 8'd120;
      step(t);
      outs("fault_enter", c_FAULT, 0, 0, 0, 1);
      wait_ticks(2);
      outs("fault_hold", c_FAULT, 0, 0, 0, 1);
      u_if.CurrentTemp = 8'd70;
      step(t);
      outs("fault_clear", c_IDLE, 0, 0, 0, 0);
      run_until("post_fault_heat", c_HEAT, nt);
      check("post_fault_ticks", 16'(nt), 16'd6);

      // Asynchronous reset mid-HEAT, then immediate restart
      #2 Reset_n = 1'b0;
      #1 outs("async_reset", c_IDLE, 0, 0, 0, 0);
      u_if.CurrentTemp = 8'd69;
      Reset_n = 1'b1;
      step(t);
      outs("heat_after_reset", c_HEAT, 1, 0, 1, 0);

      // Fault threshold boundary
      u_if.Enable = 1'b0;
      step(t);
      outs("disable_heat", c_HPURGE, 0, 0, 1, 0);
      run_until("disable_idle", c_IDLE, nt);
      u_if.CurrentTemp = 8'd99;
      wait_ticks(1);
      outs("temp99", c_IDLE, 0, 0, 0, 0);
      u_if.CurrentTemp = 8'd100;
      step(t);
      outs("temp100", c_FAULT, 0, 0, 0, 1);

`ifdef HVAC_FAN_ON_EN
      u_if.FanOn = 1'b1;
      step(t);
      outs("fanon_fault", c_FAULT, 0, 0, 0, 1);
      u_if.CurrentTemp = 8'd72;
      step(t);
      outs("fanon_idle", c_IDLE, 0, 0, 1, 0);
      u_if.FanOn = 1'b0;
      step(t);
      outs("fanoff_idle", c_IDLE, 0, 0, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
